// File: rtl/imem_loader.sv
// imem_loader: boot-time loader. It packs a byte stream into little-endian
// 32-bit words and writes them to consecutive RAM word addresses. The CPU is
// held in reset while a load is in progress.
// Optional readback verify pass: define LOADER_VERIFY_EN.
module imem_loader #(
    parameter int unsigned memWords  = 100,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        last,
    output logic        byte_ready,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic [3:0]  mem_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [31:0] word_count
);
    // state   | meaning
    // S_IDLE  | out of reset, waiting for start
    // S_RECV  | accepting bytes into the word buffer
    // S_WRITE | issuing one RAM write (or refusing it on overflow)
    // S_VRD   | readback: RAM read strobe for one word (verify build)
    // S_VCMP  | readback: fold returned word into checksum (verify build)
    // S_DONE  | load finished cleanly
    // S_ERR   | load failed (overflow or readback mismatch)
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_VERIFY_EN
        S_VRD,
        S_VCMP,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(memWords);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] buf_q, buf_d;
    logic        last_seen_q, last_seen_d;
    logic [31:0] count_q, count_d;
    logic        byte_ready_q, byte_ready_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_write_q, mem_write_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [31:0] word_v;
    logic [3:0]  mask_v;

`ifdef LOADER_VERIFY_EN
    logic        mem_read_q, mem_read_d;
    logic [31:0] csum_q, csum_d;
    logic [31:0] rb_addr_q, rb_addr_d;
    logic [31:0] rb_cnt_q, rb_cnt_d;
    logic [31:0] rb_csum_q, rb_csum_d;
    logic [3:0]  last_mask_q, last_mask_d;
    logic [31:0] rd_word_v;
    logic [31:0] rb_csum_v;
`else
    logic        unused_mem_data;
    assign unused_mem_data = ^mem_data_out;
`endif

    // Next-state and next-output computation; outputs are registered from the next state.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        last_seen_d = last_seen_q;
        count_d     = count_q;
        mem_addr_d  = 32'h0;
        mem_write_d = 4'b0000;
        mem_data_d  = 32'h0;
        word_v      = buf_q | (32'(byte_data) << {lane_q, 3'b000});
        mask_v      = 4'b1111 >> (2'd3 - lane_q);
`ifdef LOADER_VERIFY_EN
        mem_read_d  = 1'b0;
        csum_d      = csum_q;
        rb_addr_d   = rb_addr_q;
        rb_cnt_d    = rb_cnt_q;
        rb_csum_d   = rb_csum_q;
        last_mask_d = last_mask_q;
        rd_word_v   = mem_data_out;
        rb_csum_v   = rb_csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_RECV;
                    addr_d      = BASE_ADDR;
                    lane_d      = 2'd0;
                    buf_d       = 32'h0;
                    last_seen_d = 1'b0;
                    count_d     = 32'h0;
`ifdef LOADER_VERIFY_EN
                    csum_d      = 32'h0;
`endif
                end
            end
            S_RECV: begin
                if (byte_valid && byte_ready_q) begin
                    buf_d  = word_v;
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3 || last) begin
                        state_d     = S_WRITE;
                        last_seen_d = last;
`ifdef LOADER_VERIFY_EN
                        last_mask_d = mask_v;
`endif
                        // Write is presented during the WRITE cycle unless the RAM is full.
                        if (count_q != MAX_WORDS) begin
                            mem_write_d = mask_v;
                            mem_addr_d  = addr_q;
                            mem_data_d  = word_v;
                        end
                    end
                end
            end
            S_WRITE: begin
                if (count_q == MAX_WORDS) begin
                    state_d = S_ERR;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    count_d = count_q + 32'd1;
                    lane_d  = 2'd0;
                    buf_d   = 32'h0;
`ifdef LOADER_VERIFY_EN
                    csum_d  = csum_q ^ buf_q;
                    if (last_seen_q) begin
                        state_d    = S_VRD;
                        rb_addr_d  = BASE_ADDR;
                        rb_cnt_d   = 32'h0;
                        rb_csum_d  = 32'h0;
                        mem_read_d = 1'b1;
                        mem_addr_d = BASE_ADDR;
                    end else begin
                        state_d = S_RECV;
                    end
`else
                    state_d = last_seen_q ? S_DONE : S_RECV;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            S_VRD: begin
                state_d = S_VCMP;
            end
            S_VCMP: begin
                // The final word only carries the lanes that were actually written.
                if (rb_cnt_q + 32'd1 == count_q) begin
                    for (int k = 0; k < 4; k++) begin
                        if (!last_mask_q[k]) rd_word_v[8*k +: 8] = 8'h00;
                    end
                end
                rb_csum_v = rb_csum_q ^ rd_word_v;
                rb_csum_d = rb_csum_v;
                rb_addr_d = rb_addr_q + 32'd4;
                rb_cnt_d  = rb_cnt_q + 32'd1;
                if (rb_cnt_q + 32'd1 == count_q) begin
                    state_d = (rb_csum_v == csum_q) ? S_DONE : S_ERR;
                end else begin
                    state_d    = S_VRD;
                    mem_read_d = 1'b1;
                    mem_addr_d = rb_addr_q + 32'd4;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        byte_ready_d = (state_d == S_RECV);
        cpu_hold_d   = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR);
        done_d       = (state_d == S_DONE || state_d == S_ERR);
        error_d      = (state_d == S_ERR);
    end

    // State and registered outputs; asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            lane_q       <= 2'd0;
            buf_q        <= 32'h0;
            last_seen_q  <= 1'b0;
            count_q      <= 32'h0;
            byte_ready_q <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_write_q  <= 4'b0000;
            mem_data_q   <= 32'h0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef LOADER_VERIFY_EN
            mem_read_q   <= 1'b0;
            csum_q       <= 32'h0;
            rb_addr_q    <= 32'h0;
            rb_cnt_q     <= 32'h0;
            rb_csum_q    <= 32'h0;
            last_mask_q  <= 4'b0000;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lane_q       <= lane_d;
            buf_q        <= buf_d;
            last_seen_q  <= last_seen_d;
            count_q      <= count_d;
            byte_ready_q <= byte_ready_d;
            mem_addr_q   <= mem_addr_d;
            mem_write_q  <= mem_write_d;
            mem_data_q   <= mem_data_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef LOADER_VERIFY_EN
            mem_read_q   <= mem_read_d;
            csum_q       <= csum_d;
            rb_addr_q    <= rb_addr_d;
            rb_cnt_q     <= rb_cnt_d;
            rb_csum_q    <= rb_csum_d;
            last_mask_q  <= last_mask_d;
`endif
        end
    end

    assign byte_ready  = byte_ready_q;
    assign mem_addr    = mem_addr_q;
    assign mem_write   = mem_write_q;
    assign mem_data_in = mem_data_q;
    assign cpu_hold    = cpu_hold_q;
    assign done        = done_q;
    assign error       = error_q;
    assign word_count  = count_q;
`ifdef LOADER_VERIFY_EN
    assign mem_read    = mem_read_q;
`else
    assign mem_read    = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes an instruction image into the instruction RAM through the RAM's write port. It accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. Each word is issued as a byte-enabled write to consecutive word addresses. While loading, the loader holds the CPU in reset; on completion it reports a word count, done and error.

## Interface
- memWords, 100: capacity of the target RAM in 32-bit words; writes beyond it are refused.
- BASE_ADDR, 32'h0: byte address of the first word written; must be 4-byte aligned.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_valid  in  1  byte_data/last valid.
- byte_data  in  8  image byte, little-endian order.
- last  in  1  qualifies the final byte of the image.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  32  byte address to RAM addr.
- mem_read  out  1  RAM read strobe.
- mem_write  out  4  RAM byte write enables; bit n enables DATA_IN[8n+7:8n].
- mem_data_in  out  32  write data to RAM DATA_IN.
- mem_data_out  in  32  RAM DATA_OUT; used only by verify.
- cpu_hold  out  1  high while busy; drives the CPU reset request.
- done  out  1  load finished; held until the next start.
- error  out  1  load failed; sticky until the next start.
- word_count  out  32  words written this load.

## Operation
- States: IDLE, RECV, WRITE, VRD, VCMP, DONE, ERR. VRD and VCMP exist only with LOADER_VERIFY_EN.
- IDLE/DONE/ERR + start:
  - go to RECV.
  - addr=BASE_ADDR, lane=0, word buffer=0, word_count=0, checksum=0.
  - clear done and error.
- start in any other state is ignored.
- RECV:
  - byte_ready=1.
  - On byte_valid && byte_ready, byte_data goes to lane `lane` (lane 0 is bits [7:0]), then lane increments.
  - Enter WRITE after lane 3 is accepted, or after a byte with last=1 is accepted.
  - Unfilled lanes of the word are 0.
- WRITE (one cycle):
  - byte_ready=0.
  - If word_count==memWords: no write; go to ERR.
  - Otherwise:
    - mem_addr=addr, mem_data_in=word, mem_write=mask of filled lanes (4'b1111 for a full word; 4'b0001, 4'b0011 or 4'b0111 for a partial last word).
    - checksum ^= word; addr += 4; word_count += 1; lane=0; buffer=0.
    - If last was seen: go to VRD (verify) or DONE. Otherwise go to RECV.
- Addresses are 32 bits and increment by 4. They cannot wrap within memWords, because overflow goes to ERR first.
- DONE: done=1. ERR: done=1, error=1. cpu_hold=0 in both.
- cpu_hold=1 in RECV, WRITE, VRD and VCMP.
- mem_write=0 in every state other than WRITE. mem_read=0 in every state other than VRD.

## Timing
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - Every output is 0: byte_ready, mem_*, cpu_hold, done, error, word_count.
- Reset in the middle of a load aborts it. Words already written remain in RAM.
- The RAM captures a write on the rising edge at which mem_write!=0.
- The RAM presents read data on mem_data_out one cycle after mem_read/mem_addr.
- Full word: 4 accept cycles plus 1 WRITE cycle, so at most one word every 5 cycles. Gaps in byte_valid add cycles 1:1.
- done rises in the cycle after the final WRITE (no verify) or after the final VCMP (with verify).
- The byte_valid/last sampled on the same edge as start are ignored, because byte_ready is 0 in IDLE.

## Configuration
- LOADER_VERIFY_EN defined:
  - After the final write, go to VRD with the readback address at BASE_ADDR. Per word:
    - VRD: mem_read=1, mem_addr=readback address.
    - VCMP: sample mem_data_out; mask the final word with its write mask; XOR into the readback checksum; advance the readback address.
  - Repeat for word_count words.
  - Match: go to DONE. Mismatch: go to ERR.
  - Cost: 2 extra cycles per word.
- Undefined:
  - The VRD/VCMP states and the checksum logic are absent.
  - mem_read is tied to 0 and mem_data_out is unused.
  - The final WRITE goes directly to DONE.

## Test plan
- Full words: start, then bytes 13 00 00 00 93 00 10 00 with last on the 8th.
  - Writes 0x00000013 @0x0 and 0x00100093 @0x4, both with mask 4'b1111.
  - word_count=2, done=1, error=0, cpu_hold falls.
- Partial final word: bytes 11 22 33 44 55, last on 0x55.
  - Writes 0x44332211 @0x0 mask 4'b1111, then 0x00000055 @0x4 mask 4'b0001.
  - word_count=2.
- Overflow: memWords=2, 12 bytes.
  - Only addresses 0x0 and 0x4 are written.
  - error=1, done=1, word_count=2.
- Handshake: byte_valid toggled every other cycle; start pulsed during RECV.
  - Same RAM contents as the full-words case; start has no effect; one WRITE cycle per 4 bytes accepted.
- Reset mid-load: rst low after the 6th byte.
  - All outputs are 0 immediately.
  - A following start plus the full image reloads correctly.
- Verify (LOADER_VERIFY_EN):
  - Clean RAM model: done=1, error=0, with 2 read cycles after the last write.
  - RAM model flips bit 0 of word 0 after its write: error=1.
